matvec_sequencer: RTL and testbench
===================================

# matvec_sequencer

Controller for the 8×8 matrix–vector datapath: 8 row FIFOs (A), 1 vector FIFO (B) and an 8-deep systolic MAC chain. On `start` it fetches 9 64-bit words from the Avalon-MM memory wrapper and unpacks each into bytes for the correct FIFO. It then enables the MAC chain for one pass, waits for the pipeline to drain, and raises `done`. It replaces the ad-hoc fill/calc logic in the top level and is the single owner of memory reads, FIFO writes and MAC enable/clear.

## Interface
- `DATA_WIDTH`, 8: byte width of FIFO/MAC operands.
- `NUM_ROWS`, 8: number of A FIFOs, MACs and drain cycles.
- `NUM_COLS`, 8: bytes per memory word; also the number of compute cycles.
- `ADDR_WIDTH`, 32: memory address width.
- `BASE_ADDR`, 0: word address of the B vector. A row r is at `BASE_ADDR+1+r`.

Ports:
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  run request, sampled in IDLE/DONE.
- `busy`  out  1  high from the cycle after `start` is accepted until DONE.
- `done`  out  1  high in DONE; held until the next accepted `start`.
- `address`  out  ADDR_WIDTH  memory word address.
- `read`  out  1  memory read request.
- `readdata`  in  NUM_COLS*DATA_WIDTH  memory read data.
- `readdatavalid`  in  1  `readdata` is valid.
- `waitrequest`  in  1  memory is stalling the request.
- `fifo_wdata`  out  DATA_WIDTH  byte written to the selected FIFO.
- `wrreq_A`  out  NUM_ROWS  one-hot write strobe, A row FIFOs.
- `wrreq_B`  out  1  write strobe, B FIFO.
- `wrfull_A`  in  NUM_ROWS  A FIFO full flags.
- `wrfull_B`  in  1  B FIFO full flag.
- `mac_clr`  out  1  clears all MAC accumulators.
- `calc_en`  out  1  enable into MAC 0 / FIFO read chain; the datapath propagates it down the chain.

## Operation
- States: IDLE, CLEAR, REQ, WAIT, UNPACK, CALC, DRAIN, DONE.
- IDLE: `start`=1 → CLEAR.
- CLEAR: one cycle with `mac_clr`=1, word index w=0 → REQ.
- REQ: `read`=1 and `address`=BASE_ADDR+w. Both are held stable while `waitrequest`=1. When `read & ~waitrequest` at an edge → WAIT.
- WAIT: `read`=0. On `readdatavalid`=1, latch `readdata` into the word register and set byte index b=0 → UNPACK.
- UNPACK: `fifo_wdata` = byte b, LSB byte first (bits [8b+7:8b]).
  - w=0 targets B. w≥1 targets A row w−1.
  - If the target FIFO is not full: the strobe is 1 and b increments.
  - If the target FIFO is full: the strobe is 0, b and the data hold, and the byte retries next cycle.
  - After byte NUM_COLS−1 is written: if w<NUM_ROWS, w increments → REQ; else → CALC.
- CALC: `calc_en`=1 for exactly NUM_COLS consecutive cycles → DRAIN.
- DRAIN: `calc_en`=0 for NUM_ROWS cycles → DONE.
- DONE: `done`=1, `busy`=0. `start`=1 → CLEAR, and `done` drops in that cycle.
- Only one read is outstanding at a time. `readdatavalid` outside WAIT is ignored.
- `start` outside IDLE/DONE is ignored.
- Counters w and b are sized for values up to NUM_ROWS and NUM_COLS. They never wrap within a run.

## Timing
- Reset values: state=IDLE, and every output 0 (`address`=0, `read`=0, `busy`=0, `done`=0, all strobes 0, `mac_clr`=0, `calc_en`=0).
- Reset asserted in any state aborts the run immediately. No partial FIFO write completes after `rst_n` falls.
- All outputs are registered or decoded from state/counters only. There is no combinational path from `readdata`/`readdatavalid` to the outputs.
- `wrfull_*` gates the strobe combinationally in the same cycle.
- Per word with zero wait-states and read latency L: 1 cycle in REQ, L cycles in WAIT, NUM_COLS cycles in UNPACK.
- Full run with zero wait-states and no FIFO stalls:
  - 1 cycle CLEAR.
  - 9·(1+L+8) cycles of fetch.
  - 8 cycles CALC.
  - 8 cycles DRAIN.
  - Then `done`=1.
- Simultaneous `readdatavalid` and state exit are impossible by construction, because there is one outstanding read.

## Test plan
- Nominal run: memory model with L=2, no waitrequest; word k = bytes {k,k+1,…,k+7}. Required:
  - Reads at addresses 0..8, in order.
  - B receives 0..7; A row 3 receives 4..11.
  - `calc_en` high exactly 8 cycles.
  - `done` rises 1+9·11+16=116 cycles after the CLEAR cycle begins.
- Waitrequest: hold `waitrequest`=1 for 3 cycles on word 4. Required: `read`=1 and `address`=4 stable for 4 cycles, exactly one read accepted, and run total +3 cycles.
- FIFO full: hold `wrfull_A[2]`=1 for 5 cycles while byte 3 of word 3 is pending. Required: `wrreq_A`=0, `fifo_wdata` held at the byte-3 value, byte 3 written once when full clears, and no byte dropped or duplicated.
- Spurious valid/start: pulse `readdatavalid` in UNPACK and `start` in CALC. Required: no change to FIFO contents or sequencing, and no restart.
- Reset mid-run: drop `rst_n` during UNPACK of word 5. Required: all outputs 0 asynchronously. After release, `start` runs a clean full sequence from address 0.
- Back-to-back runs: `start` in DONE. Required: `done`→0 and `mac_clr` pulses for 1 cycle the next cycle; the second run is identical to the first.

Source files
------------

// File: rtl/matvec_sequencer_if.sv
// Avalon-MM read-only bus between the matvec sequencer (master) and the memory wrapper (slave).
interface matvec_sequencer_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int WORD_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] address;
    logic                  read;
    logic [WORD_WIDTH-1:0] readdata;
    logic                  readdatavalid;
    logic                  waitrequest;

    // read/address are held while waitrequest=1; a read is accepted on an edge
    // with read=1 and waitrequest=0; readdatavalid later qualifies readdata for one cycle.
    modport master (
        output address, read,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/matvec_sequencer.sv
// Sequencer for the 8x8 matrix-vector datapath: fetches B then A rows from memory,
// unpacks them byte-wise into the FIFOs, runs one MAC pass and waits for the drain.
module matvec_sequencer #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_ROWS   = 8,
    parameter int                    NUM_COLS   = 8,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    matvec_sequencer_if.master    mem,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic [NUM_ROWS-1:0]   wrreq_A,
    output logic                  wrreq_B,
    input  logic [NUM_ROWS-1:0]   wrfull_A,
    input  logic                  wrfull_B,
    output logic                  mac_clr,
    output logic                  calc_en,
    output logic [2:0]            dbg_state
);
    localparam int WORD_W = NUM_COLS * DATA_WIDTH;
    localparam int W_W    = $clog2(NUM_ROWS + 1);
    localparam int B_W    = $clog2(NUM_COLS + 1);
    localparam int C_MAX  = (NUM_ROWS > NUM_COLS) ? NUM_ROWS : NUM_COLS;
    localparam int C_W    = $clog2(C_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_REQ    = 3'd2,
        S_WAIT   = 3'd3,
        S_UNPACK = 3'd4,
        S_CALC   = 3'd5,
        S_DRAIN  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t              state_q, state_d;
    logic [W_W-1:0]      w_q, w_d;
    logic [B_W-1:0]      b_q, b_d;
    logic [C_W-1:0]      cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [DATA_WIDTH-1:0] sel_byte;
    logic                tgt_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

    // Current byte and full flag of the FIFO that word w feeds (w=0 is B, else A row w-1).
    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (b_q == B_W'(i)) sel_byte = word_q[i*DATA_WIDTH +: DATA_WIDTH];
        end
        tgt_full = wrfull_B;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (w_q == W_W'(r + 1)) tgt_full = wrfull_A[r];
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                w_d     = '0;
                state_d = S_REQ;
            end
            S_REQ: begin
                if (!mem.waitrequest) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem.readdatavalid) begin
                    word_d  = mem.readdata;
                    b_d     = '0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (!tgt_full) begin
                    b_d = b_q + 1'b1;
                    if (b_q == B_W'(NUM_COLS - 1)) begin
                        if (w_q < W_W'(NUM_ROWS)) begin
                            w_d     = w_q + 1'b1;
                            state_d = S_REQ;
                        end else begin
                            cnt_d   = '0;
                            state_d = S_CALC;
                        end
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_W'(NUM_COLS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_W'(NUM_ROWS - 1)) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode state/counters only, so reset forces them all to 0 at once.
    always_comb begin
        mem.read    = (state_q == S_REQ);
        mem.address = (state_q == S_REQ) ? (BASE_ADDR + ADDR_WIDTH'(w_q)) : '0;
        busy        = (state_q != S_IDLE) && (state_q != S_DONE);
        done        = (state_q == S_DONE);
        mac_clr     = (state_q == S_CLEAR);
        calc_en     = (state_q == S_CALC);
        fifo_wdata  = (state_q == S_UNPACK) ? sel_byte : '0;
        wrreq_B     = (state_q == S_UNPACK) && (w_q == '0) && !wrfull_B;
        wrreq_A     = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            wrreq_A[r] = (state_q == S_UNPACK) && (w_q == W_W'(r + 1)) && !wrfull_A[r];
        end
        dbg_state   = state_q;
    end
endmodule

// File: tb/tb_matvec_sequencer.sv
// Directed bench for matvec_sequencer: table of full runs plus reset-abort sequence.
module tb_matvec_sequencer;
    localparam int RD_LAT = 2;

    typedef struct {
        int wr_word;      // word whose REQ is stalled by waitrequest (-1: none)
        int wr_cycles;
        int full_idx;     // 0 = B FIFO, k = A row k-1 (-1: none)
        int full_byte;
        int full_cycles;
        int spur_rdv_at;  // write count at which a stray readdatavalid is pulsed (-1: none)
        bit spur_start;   // pulse start during CALC
        int exp_cycles;   // cycles from CLEAR start until done
    } run_vec_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy, done;
    logic [7:0]  fifo_wdata;
    logic [7:0]  wrreq_A;
    logic        wrreq_B;
    logic [7:0]  wrfull_A;
    logic        wrfull_B;
    logic        mac_clr, calc_en;
    logic [2:0]  dbg_state;

    matvec_sequencer_if #(.ADDR_WIDTH(32), .WORD_WIDTH(64)) bus ();

    matvec_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem        (bus.master),
        .fifo_wdata (fifo_wdata),
        .wrreq_A    (wrreq_A),
        .wrreq_B    (wrreq_B),
        .wrfull_A   (wrfull_A),
        .wrfull_B   (wrfull_B),
        .mac_clr    (mac_clr),
        .calc_en    (calc_en),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // memory model: word k holds bytes k..k+7 (LSB first)
    function automatic logic [63:0] word_of(input logic [31:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'(a + 32'(i));
        return w;
    endfunction

    logic        mem_rdv, pend, spur_rdv;
    int          lat;
    logic [31:0] pend_addr;
    logic [63:0] mem_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdv <= 1'b0;
            pend    <= 1'b0;
            lat     <= 0;
            pend_addr <= '0;
            mem_data <= '0;
        end else begin
            mem_rdv <= 1'b0;
            if (pend) begin
                if (lat == 1) begin
                    mem_rdv  <= 1'b1;
                    mem_data <= word_of(pend_addr);
                    pend     <= 1'b0;
                end else begin
                    lat <= lat - 1;
                end
            end
            if (bus.read && !bus.waitrequest) begin
                pend      <= 1'b1;
                lat       <= RD_LAT - 1;
                pend_addr <= bus.address;
            end
        end
    end

    assign bus.readdatavalid = mem_rdv | spur_rdv;
    assign bus.readdata      = spur_rdv ? 64'hA5A5_A5A5_A5A5_A5A5 : mem_data;

    // observers: FIFO writes as {fifo index, byte}, accepted read addresses, activity counts
    logic [11:0] cap_log[$];
    logic [31:0] addr_log[$];
    logic [11:0] exp_q[$];
    int read_cycles, calc_cycles, calc_rises, clr_cycles;
    logic calc_en_prev;

    always @(posedge clk) begin
        logic [3:0] idx;
        if (wrreq_B || (wrreq_A != 8'h00)) begin
            idx = 4'hF;
            if (wrreq_B && wrreq_A == 8'h00) idx = 4'd0;
            else if (!wrreq_B && $onehot(wrreq_A)) begin
                for (int r = 0; r < 8; r++) if (wrreq_A[r]) idx = 4'(r + 1);
            end
            cap_log.push_back({idx, fifo_wdata});
        end
        if (bus.read && !bus.waitrequest) addr_log.push_back(bus.address);
        if (bus.read) read_cycles++;
        if (mac_clr) clr_cycles++;
        if (calc_en) calc_cycles++;
        if (calc_en && !calc_en_prev) calc_rises++;
        calc_en_prev = calc_en;
    end

    function automatic logic [63:0] outs_now();
        return 64'({bus.address, bus.read, busy, done, fifo_wdata, wrreq_A, wrreq_B, mac_clr, calc_en});
    endfunction

    // driver: called at a negedge in IDLE/DONE; runs one sequence, or aborts it with reset
    task automatic run_one(input run_vec_t v, input int abort_at, output bit aborted);
        int n;
        int wr_left, full_left;
        bit wr_active, wr_post, spur_rdv_done, spur_start_done;
        cap_log.delete();
        addr_log.delete();
        exp_q.delete();
        read_cycles = 0; calc_cycles = 0; calc_rises = 0; clr_cycles = 0; calc_en_prev = 1'b0;
        for (int k = 0; k < 9; k++)
            for (int b = 0; b < 8; b++) exp_q.push_back({4'(k), 8'(k + b)});
        aborted = 1'b0;
        wr_left = v.wr_cycles; full_left = v.full_cycles;
        wr_active = 0; wr_post = 0; spur_rdv_done = 0; spur_start_done = 0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("clear_mac_clr", 64'(mac_clr), 64'd1);
        check("clear_done_low", 64'(done), 64'd0);
        check("clear_busy", 64'(busy), 64'd1);
        n = 0;
        while (!done && n < 1000) begin
            @(negedge clk);
            n++;
            bus.waitrequest = 1'b0; wrfull_A = '0; wrfull_B = 1'b0; spur_rdv = 1'b0; start = 1'b0;
            if (abort_at >= 0 && cap_log.size() == abort_at) begin
                check("abort_pre_wrreq", 64'(wrreq_A), 64'h10);
                check("abort_pre_data", 64'(fifo_wdata), 64'd8);
                #1 rst_n = 1'b0;
                #1 check("abort_outs_zero", outs_now(), 64'd0);
                aborted = 1'b1;
                break;
            end
            if (v.wr_word >= 0 && wr_left > 0 &&
                (wr_active || (bus.read && bus.address == 32'(v.wr_word)))) begin
                if (wr_active) begin
                    check("wait_read_held", 64'(bus.read), 64'd1);
                    check("wait_addr_held", 64'(bus.address), 64'(v.wr_word));
                end
                wr_active = 1; bus.waitrequest = 1'b1; wr_left--;
            end else if (wr_active && !wr_post) begin
                wr_post = 1;
                check("wait_read_final", 64'(bus.read), 64'd1);
                check("wait_addr_final", 64'(bus.address), 64'(v.wr_word));
            end
            if (v.spur_rdv_at >= 0 && !spur_rdv_done && cap_log.size() == v.spur_rdv_at) begin
                spur_rdv = 1'b1; spur_rdv_done = 1;
            end
            if (v.spur_start && !spur_start_done && calc_en) begin
                start = 1'b1; spur_start_done = 1;
            end
            if (v.full_idx >= 0 && full_left > 0 &&
                cap_log.size() == 8 * v.full_idx + v.full_byte) begin
                if (v.full_idx == 0) wrfull_B = 1'b1;
                else wrfull_A[v.full_idx - 1] = 1'b1;
                full_left--;
                #1;
                check("stall_strobes", 64'({wrreq_A, wrreq_B}), 64'd0);
                check("stall_data", 64'(fifo_wdata), 64'(v.full_idx + v.full_byte));
            end
        end
        if (aborted) return;
        bus.waitrequest = 1'b0; wrfull_A = '0; wrfull_B = 1'b0; spur_rdv = 1'b0; start = 1'b0;

        check("done_latency", 64'(n), 64'(v.exp_cycles));
        check("done_busy_low", 64'(busy), 64'd0);
        check("read_count", 64'(addr_log.size()), 64'd9);
        for (int i = 0; i < addr_log.size() && i < 9; i++)
            check("read_addr", 64'(addr_log[i]), 64'(i));
        check("read_cycles", 64'(read_cycles), 64'(9 + v.wr_cycles));
        check("write_count", 64'(cap_log.size()), 64'(exp_q.size()));
        for (int i = 0; i < cap_log.size() && i < exp_q.size(); i++)
            check("write_entry", 64'(cap_log[i]), 64'(exp_q[i]));
        check("calc_cycles", 64'(calc_cycles), 64'd8);
        check("calc_rises", 64'(calc_rises), 64'd1);
        check("mac_clr_cycles", 64'(clr_cycles), 64'd1);
    endtask

    run_vec_t vecs[7];
    run_vec_t nominal;

    initial begin
        bit ab;
        //          wr_w wr_c full_i full_b full_c spur_rdv spur_st exp
        vecs[0] = '{-1, 0, -1, 0, 0, -1, 1'b0, 116};  // nominal
        vecs[1] = '{ 4, 3, -1, 0, 0, -1, 1'b0, 119};  // waitrequest on word 4
        vecs[2] = '{-1, 0,  3, 3, 5, -1, 1'b0, 121};  // A row 2 full at byte 3
        vecs[3] = '{-1, 0, -1, 0, 0, 20, 1'b1, 116};  // stray valid and start
        vecs[4] = '{ 8, 2,  8, 7, 3, -1, 1'b0, 121};  // last word stalls, last byte full
        vecs[5] = '{-1, 0,  0, 5, 2, -1, 1'b0, 118};  // B full at byte 5
        vecs[6] = '{-1, 0, -1, 0, 0, -1, 1'b0, 116};  // back-to-back repeat
        nominal = vecs[0];

        rst_n = 1'b0; start = 1'b0; bus.waitrequest = 1'b0;
        wrfull_A = '0; wrfull_B = 1'b0; spur_rdv = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs_zero", outs_now(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outs_zero", outs_now(), 64'd0);

        for (int i = 0; i < 7; i++) run_one(vecs[i], -1, ab);

        // abort during UNPACK of word 5 (byte 3 pending), then a clean run from address 0
        run_one(nominal, 5 * 8 + 3, ab);
        check("abort_taken", 64'(ab), 64'd1);
        repeat (2) @(negedge clk);
        check("abort_no_late_write", 64'(cap_log.size()), 64'd43);
        check("abort_held_zero", outs_now(), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_one(nominal, -1, ab);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
